alu_cmd_sequencer: RTL and testbench
====================================

ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

Upstream command serializer: converts one parallel command into the byte-serial ctl/dat stream consumed by the ALU math stage, waits for that stage's ready pulse, and returns its result.

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16: maximum cycles spent in WAIT for alu_ready before aborting.
REQ-002 SHALL have port clk  input  1  clock; all flops rising-edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port cmd_valid  input  1  command request.
REQ-005 SHALL have port cmd_ready  output  1  command accepted when cmd_valid and cmd_ready are both high.
REQ-006 SHALL have port cmd_op  input  4  opcode: 0 ADD, 1 SUB_AB, 2 SUB_BA, 3 MUL, 4 DIV_AB, 5 DIV_BA, 6 INC_A, 7 INC_B, 8 CLR, 9 ACCUM.
REQ-007 SHALL have port cmd_a  input  16  operand A.
REQ-008 SHALL have port cmd_b  input  16  operand B.
REQ-009 SHALL have port alu_ctl  output  1  opcode-strobe to the math stage.
REQ-010 SHALL have port alu_dat  output  8  opcode/operand byte to the math stage.
REQ-011 SHALL have port alu_ready  input  1  one-cycle completion pulse from the math stage.
REQ-012 SHALL have port alu_result  input  32  math-stage result; valid in the cycle alu_ready is high.
REQ-013 SHALL have port rsp_valid  output  1  response available.
REQ-014 SHALL have port rsp_ready  input  1  response consumed when rsp_valid and rsp_ready are both high.
REQ-015 SHALL have port rsp_result  output  32  captured result.
REQ-016 SHALL have port rsp_err  output  2  00 ok, 01 illegal opcode, 10 timeout.

Function
REQ-017 SHALL implement FSM states IDLE, SEND_OP, SEND_AM, SEND_AL, SEND_BM, SEND_BL, WAIT, RESP.
REQ-018 SHALL drive cmd_ready=1 only in IDLE.
REQ-019 SHALL, on acceptance, latch cmd_op, cmd_a and cmd_b; SHALL go to RESP with rsp_err=01 if cmd_op>9, otherwise to SEND_OP.
REQ-020 SHALL drive alu_ctl and alu_dat from flops so that the following values appear in the same cycle the FSM occupies the state: SEND_OP ctl=1 with dat={4'h0,op}; SEND_AM dat=A[15:8]; SEND_AL dat=A[7:0]; SEND_BM dat=B[15:8]; SEND_BL dat=B[7:0]; all other states ctl=0, dat=0.
REQ-021 SHALL sequence from SEND_OP as follows: ops 0-5 -> AM,AL,BM,BL; ops 6,9 -> AM,AL; op 7 -> BM,BL; op 8 -> directly to WAIT; the last byte state SHALL go to WAIT; each SEND state SHALL last exactly one cycle, so bytes are back-to-back.
REQ-022 SHALL assert alu_ctl for exactly one cycle per accepted legal command, and never for illegal commands.
REQ-023 SHALL, in WAIT, run a counter cleared on WAIT entry and incremented each cycle.
REQ-024 SHALL, when alu_ready=1 in WAIT, capture alu_result into rsp_result, set rsp_err=00 and go to RESP.
REQ-025 SHALL, when the counter reaches TIMEOUT without alu_ready, set rsp_err=10 and rsp_result=0 and go to RESP.
REQ-026 SHALL treat alu_ready=1 in the same cycle the counter reaches TIMEOUT as success.
REQ-027 SHALL ignore alu_ready in any state other than WAIT.
REQ-028 SHALL hold rsp_valid=1 in RESP with rsp_result/rsp_err stable until rsp_ready=1, then return to IDLE; rsp_ready=1 on RESP entry SHALL complete in that cycle.
REQ-029 SHALL require minimum command-to-command spacing of two cycles (RESP then IDLE); the block SHALL never accept while a command is in flight.

Reset
REQ-030 SHALL, with rst_n low at any time including mid-sequence, asynchronously force state=IDLE, alu_ctl=0, alu_dat=0, rsp_valid=0, rsp_result=0, rsp_err=00 and counter=0, discarding any in-flight command.
REQ-031 SHALL drive cmd_ready=1 in the first cycle after rst_n deasserts.

Verification
REQ-032 SHALL cover: ADD, A=0x1234, B=0x0056 -> alu_ctl=1 with dat=00 for one cycle, then 12,34,00,56 on consecutive cycles; alu_ready pulsed with alu_result=0x0000128A -> rsp_valid with rsp_result=0x0000128A and rsp_err=00.
REQ-033 SHALL cover: INC_B, B=0xBEEF -> dat 07 (ctl=1), EF? no: BE then EF, no A bytes; op CLR -> only the 08 strobe, no operand bytes.
REQ-034 SHALL cover: cmd_op=0xC -> no alu_ctl pulse, rsp_err=01 on the next cycle.
REQ-035 SHALL cover: MUL with alu_ready never asserted -> rsp_err=10 and rsp_result=0 after TIMEOUT WAIT cycles; the block then accepts a new command.
REQ-036 SHALL cover: rsp_ready held low 5 cycles -> rsp_valid and rsp_result stable and cmd_ready=0 throughout; the response completes when rsp_ready rises.
REQ-037 SHALL cover: rst_n pulsed low during SEND_AL -> all outputs immediately at reset values, no further bytes, cmd_ready=1 after release.

Source files
------------

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: turns one parallel ALU command into a byte-serial
// ctl/dat stream for the math stage. It then waits, with a bounded timeout,
// for the stage's ready pulse and hands the result back on a valid/ready
// response port.
module alu_cmd_sequencer #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_op,
    input  logic [15:0] cmd_a,
    input  logic [15:0] cmd_b,
    output logic        alu_ctl,
    output logic [7:0]  alu_dat,
    input  logic        alu_ready,
    input  logic [31:0] alu_result,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic [1:0]  rsp_err
);

    localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    // WAIT spans at most TIMEOUT cycles; this is the count seen in the last one.
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SEND_OP = 3'd1,
        SEND_AM = 3'd2,
        SEND_AL = 3'd3,
        SEND_BM = 3'd4,
        SEND_BL = 3'd5,
        WAIT    = 3'd6,
        RESP    = 3'd7
    } state_t;

    state_t         r_state;
    state_t         w_state_n;
    logic [3:0]     r_op;
    logic [15:0]    r_a;
    logic [15:0]    r_b;
    logic [CW-1:0]  r_cnt;
    logic           r_alu_ctl;
    logic [7:0]     r_alu_dat;
    logic [31:0]    r_rsp_result;
    logic [1:0]     r_rsp_err;

    logic           w_accept;
    logic           w_illegal;
    logic           w_rsp_load;
    logic [31:0]    w_rsp_result_n;
    logic [1:0]     w_rsp_err_n;
    logic [3:0]     w_op_n;
    logic [15:0]    w_a_n;
    logic [15:0]    w_b_n;
    logic           w_ctl_n;
    logic [7:0]     w_dat_n;

    assign w_accept  = cmd_valid && (r_state == IDLE);
    assign w_illegal = (cmd_op > 4'd9);

    // Operand view for the next cycle: fresh inputs on acceptance, latched copy otherwise.
    assign w_op_n = w_accept ? cmd_op : r_op;
    assign w_a_n  = w_accept ? cmd_a  : r_a;
    assign w_b_n  = w_accept ? cmd_b  : r_b;

    assign cmd_ready  = (r_state == IDLE);
    assign rsp_valid  = (r_state == RESP);
    assign alu_ctl    = r_alu_ctl;
    assign alu_dat    = r_alu_dat;
    assign rsp_result = r_rsp_result;
    assign rsp_err    = r_rsp_err;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_n;
    end

    // Next-state logic plus the response value to capture on leaving IDLE/WAIT.
    always_comb begin
        w_state_n      = r_state;
        w_rsp_load     = 1'b0;
        w_rsp_result_n = 32'd0;
        w_rsp_err_n    = ERR_OK;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_illegal) begin
                        w_state_n   = RESP;
                        w_rsp_load  = 1'b1;
                        w_rsp_err_n = ERR_ILLEGAL;
                    end else begin
                        w_state_n = SEND_OP;
                    end
                end
            end
            SEND_OP: begin
                case (r_op)
                    4'd7:    w_state_n = SEND_BM;
                    4'd8:    w_state_n = WAIT;
                    default: w_state_n = SEND_AM;
                endcase
            end
            SEND_AM: w_state_n = SEND_AL;
            // INC_A and ACCUM carry only operand A.
            SEND_AL: w_state_n = (r_op == 4'd6 || r_op == 4'd9) ? WAIT : SEND_BM;
            SEND_BM: w_state_n = SEND_BL;
            SEND_BL: w_state_n = WAIT;
            WAIT: begin
                // A ready pulse in the final counted cycle still wins over timeout.
                if (alu_ready) begin
                    w_state_n      = RESP;
                    w_rsp_load     = 1'b1;
                    w_rsp_result_n = alu_result;
                    w_rsp_err_n    = ERR_OK;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_n   = RESP;
                    w_rsp_load  = 1'b1;
                    w_rsp_err_n = ERR_TIMEOUT;
                end
            end
            RESP: begin
                if (rsp_ready) w_state_n = IDLE;
            end
            default: w_state_n = IDLE;
        endcase
    end

    // Byte to present in the next cycle, chosen by the state about to be entered.
    always_comb begin
        w_ctl_n = 1'b0;
        w_dat_n = 8'h00;
        case (w_state_n)
            SEND_OP: begin
                w_ctl_n = 1'b1;
                w_dat_n = {4'h0, w_op_n};
            end
            SEND_AM: w_dat_n = w_a_n[15:8];
            SEND_AL: w_dat_n = w_a_n[7:0];
            SEND_BM: w_dat_n = w_b_n[15:8];
            SEND_BL: w_dat_n = w_b_n[7:0];
            default: begin
                w_ctl_n = 1'b0;
                w_dat_n = 8'h00;
            end
        endcase
    end

    // Registered ALU stream outputs so ctl/dat line up with the SEND states.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_ctl <= 1'b0;
            r_alu_dat <= 8'h00;
        end else begin
            r_alu_ctl <= w_ctl_n;
            r_alu_dat <= w_dat_n;
        end
    end

    // Latch the command on acceptance so the inputs may change while it is serialized.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op <= 4'h0;
            r_a  <= 16'h0000;
            r_b  <= 16'h0000;
        end else if (w_accept) begin
            r_op <= cmd_op;
            r_a  <= cmd_a;
            r_b  <= cmd_b;
        end
    end

    // WAIT cycle counter: zeroed on entry, counts every cycle spent in WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (r_state != WAIT && w_state_n == WAIT) begin
            r_cnt <= '0;
        end else if (r_state == WAIT) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // Response holding registers; stay constant while RESP waits for rsp_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_result <= 32'd0;
            r_rsp_err    <= ERR_OK;
        end else if (w_rsp_load) begin
            r_rsp_result <= w_rsp_result_n;
            r_rsp_err    <= w_rsp_err_n;
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: a queue-based reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_alu_cmd_sequencer;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [3:0]  cmd_op = 4'h0;
  logic [15:0] cmd_a = 16'h0;
  logic [15:0] cmd_b = 16'h0;
  logic        alu_ctl;
  logic [7:0]  alu_dat;
  logic        alu_ready = 1'b0;
  logic [31:0] alu_result = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_result;
  logic [1:0]  rsp_err;

  int vectors = 0;
  int miscompares = 0;

  alu_cmd_sequencer #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_ctl(alu_ctl), .alu_dat(alu_dat),
    .alu_ready(alu_ready), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: pending stream bytes {ctl,dat}, a wait-cycle count, a response slot.
  logic [8:0]  m_q[$];
  bit          m_wait, m_resp;
  int          m_n;
  logic [31:0] m_res;
  logic [1:0]  m_err;

  function automatic bit m_idle();
    return (m_q.size() == 0) && !m_wait && !m_resp;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete(); m_wait = 0; m_resp = 0; m_n = 0; m_res = 0; m_err = 0;
    end else if (m_resp) begin
      if (rsp_ready) m_resp = 0;
    end else if (m_q.size() > 0) begin
      void'(m_q.pop_front());
      if (m_q.size() == 0) begin m_wait = 1; m_n = 0; end
    end else if (m_wait) begin
      if (alu_ready) begin
        m_wait = 0; m_resp = 1; m_res = alu_result; m_err = 2'b00;
      end else begin
        m_n++;
        if (m_n == TO) begin m_wait = 0; m_resp = 1; m_res = 0; m_err = 2'b10; end
      end
    end else if (cmd_valid) begin
      if (cmd_op > 4'd9) begin
        m_resp = 1; m_res = 0; m_err = 2'b01;
      end else begin
        m_q.push_back({1'b1, 4'h0, cmd_op});
        if (cmd_op <= 4'd6 || cmd_op == 4'd9) begin
          m_q.push_back({1'b0, cmd_a[15:8]}); m_q.push_back({1'b0, cmd_a[7:0]});
        end
        if (cmd_op <= 4'd5 || cmd_op == 4'd7) begin
          m_q.push_back({1'b0, cmd_b[15:8]}); m_q.push_back({1'b0, cmd_b[7:0]});
        end
      end
    end
  end

  // Every-cycle comparison against the model, on the falling edge.
  always @(negedge clk) begin : cmp
    logic [8:0] e;
    if (rst_n) begin
      e = (m_q.size() > 0) ? m_q[0] : 9'h000;
      chk("cmd_ready", {31'd0, cmd_ready}, {31'd0, m_idle()});
      chk("alu_stream", {23'd0, alu_ctl, alu_dat}, {23'd0, e});
      chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_resp});
      if (m_resp) begin
        chk("rsp_result", rsp_result, m_res);
        chk("rsp_err", {30'd0, rsp_err}, {30'd0, m_err});
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Present one command for one cycle; caller must have the DUT idle.
  task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    chk("issue_idle", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1; cmd_op = op; cmd_a = a; cmd_b = b;
    step();
    cmd_valid = 0;
  endtask

  task automatic strm(input string name, input logic [8:0] exp);
    chk(name, {23'd0, alu_ctl, alu_dat}, {23'd0, exp});
  endtask

  // DUT is in WAIT: return a result, then drain the response.
  task automatic finish_wait(input logic [31:0] res);
    alu_ready = 1; alu_result = res;
    step();
    alu_ready = 0;
    chk("fw_valid", {31'd0, rsp_valid}, 32'd1);
    chk("fw_result", rsp_result, res);
    chk("fw_err", {30'd0, rsp_err}, 32'd0);
    rsp_ready = 1;
    step();
    rsp_ready = 0;
    chk("fw_idle", {31'd0, cmd_ready}, 32'd1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [31:0] held;
    // Reset values
    #3;
    chk("rst_ctl", {31'd0, alu_ctl}, 32'd0);
    chk("rst_dat", {24'd0, alu_dat}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_result", rsp_result, 32'd0);
    chk("rst_rsp_err", {30'd0, rsp_err}, 32'd0);
    step(); step();
    rst_n = 1;
    step();
    chk("post_rst_ready", {31'd0, cmd_ready}, 32'd1);

    // ADD 0x1234 + 0x0056
    issue(4'd0, 16'h1234, 16'h0056);
    strm("add_op", 9'h100); step();
    strm("add_am", 9'h012); step();
    strm("add_al", 9'h034); step();
    strm("add_bm", 9'h000); step();
    strm("add_bl", 9'h056); step();
    strm("add_wait", 9'h000);
    finish_wait(32'h0000128A);

    // INC_B: opcode then B bytes only
    issue(4'd7, 16'h1111, 16'hBEEF);
    strm("incb_op", 9'h107); step();
    strm("incb_bm", 9'h0BE); step();
    strm("incb_bl", 9'h0EF); step();
    strm("incb_wait", 9'h000);
    finish_wait(32'h0000BEF0);

    // CLR: strobe only
    issue(4'd8, 16'hFFFF, 16'hFFFF);
    strm("clr_op", 9'h108); step();
    strm("clr_wait", 9'h000);
    finish_wait(32'h0);

    // Illegal opcode: response next cycle, no strobe
    issue(4'hC, 16'h1, 16'h2);
    strm("ill_stream", 9'h000);
    chk("ill_valid", {31'd0, rsp_valid}, 32'd1);
    chk("ill_err", {30'd0, rsp_err}, 32'd1);
    rsp_ready = 1; step(); rsp_ready = 0;

    // MUL with no ready: timeout after TO WAIT cycles
    issue(4'd3, 16'h00FF, 16'h0102);
    strm("mul_op", 9'h103); step(); step(); step(); step();
    strm("mul_bl", 9'h002);
    n = 0;
    while (!rsp_valid && n < 100) begin step(); n++; end
    chk("to_cycles", n, TO + 1);
    chk("to_err", {30'd0, rsp_err}, 32'd2);
    chk("to_result", rsp_result, 32'd0);
    rsp_ready = 1; step(); rsp_ready = 0;
    issue(4'd6, 16'hCAFE, 16'h0);
    strm("after_to_op", 9'h106); step();
    strm("after_to_am", 9'h0CA); step(); step();
    finish_wait(32'h0000CAFF);

    // Response backpressure for 5 cycles
    issue(4'd8, 16'h0, 16'h0);
    step();
    alu_ready = 1; alu_result = 32'hA5A5_0001;
    step();
    alu_ready = 0; alu_result = 32'h0;
    held = rsp_result;
    chk("bp_captured", held, 32'hA5A5_0001);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      chk("bp_result", rsp_result, held);
      step();
    end
    rsp_ready = 1; step(); rsp_ready = 0;
    chk("bp_done", {31'd0, rsp_valid}, 32'd0);
    chk("bp_idle", {31'd0, cmd_ready}, 32'd1);

    // Reset during SEND_AL
    issue(4'd0, 16'hA55A, 16'h1234);
    step();
    step();
    strm("rst_mid_al", 9'h05A);
    #2 rst_n = 0;
    #1;
    chk("rst_mid_ctl", {31'd0, alu_ctl}, 32'd0);
    chk("rst_mid_dat", {24'd0, alu_dat}, 32'd0);
    chk("rst_mid_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_mid_result", rsp_result, 32'd0);
    chk("rst_mid_err", {30'd0, rsp_err}, 32'd0);
    step();
    rst_n = 1;
    step();
    chk("rst_mid_ready", {31'd0, cmd_ready}, 32'd1);
    strm("rst_mid_quiet", 9'h000);
    step(); step();

    // Random traffic, including illegal opcodes and stray ready pulses
    for (int i = 0; i < 1500; i++) begin
      cmd_valid  = ($urandom_range(0, 1) == 1);
      cmd_op     = 4'($urandom_range(0, 11));
      cmd_a      = 16'($urandom);
      cmd_b      = 16'($urandom);
      alu_ready  = ($urandom_range(0, 9) == 0);
      alu_result = $urandom;
      rsp_ready  = ($urandom_range(0, 2) != 0);
      step();
    end
    cmd_valid = 0; alu_ready = 1; rsp_ready = 1;
    for (int i = 0; i < 10; i++) step();
    chk("drain_idle", {31'd0, cmd_ready}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
